inst_sequencer: RTL and testbench

//  Parametrised program sequencer: PC, branch resolution, Start/Ack run control and

---
 rtl/seq_pkg.sv | 29 ++
 rtl/sat_counter.sv | 35 +++
 rtl/inst_sequencer.sv | 139 +++++++++++++
 tb/tb_inst_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the instruction sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

  typedef logic [1:0] cond_sel_t;

  localparam cond_sel_t COND_ALW = 2'b00;
  localparam cond_sel_t COND_EQ  = 2'b01;
  localparam cond_sel_t COND_LT  = 2'b10;
  localparam cond_sel_t COND_LE  = 2'b11;

  // Evaluates the relative-branch condition from the ALU flags.
  function automatic logic cond_true(input cond_sel_t sel, input logic eq, input logic lt);
    logic r;
    case (sel)
      COND_ALW: r = 1'b1;
      COND_EQ:  r = eq;
      COND_LT:  r = lt;
      default:  r = eq | lt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops once the count is all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/inst_sequencer.sv
// Program sequencer: PC, branch resolution, Start/Ack run control,
// watchdog and saturating cycle/instruction counters.
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int                    PCW       = 10,
  parameter int                    PROGS     = 4,
  parameter logic [PROGS*PCW-1:0]  PROG_BASE = '0,
  parameter int                    CTW       = 16,
  parameter int                    TIMEOUT   = 4096,
  localparam int                   SW        = (PROGS > 1) ? $clog2(PROGS) : 1
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Start,
  input  logic [SW-1:0]  ProgSel,
  input  logic           BranchAbs,
  input  logic           BranchRelEn,
  input  logic [1:0]     CondSel,
  input  logic           ALU_equals,
  input  logic           ALU_lt,
  input  logic [PCW-1:0] Target,
  input  logic           HaltInst,
  input  logic           Stall,
  output logic [PCW-1:0] ProgCtr,
  output logic           Busy,
  output logic           Ack,
  output logic           Timeout,
  output logic [CTW-1:0] CycleCt,
  output logic [CTW-1:0] InstCt
);

  // A limit that cannot be represented in CTW bits would never be reached
  // by a saturating counter, so it behaves as a disabled watchdog.
  localparam bit             WD_EN   = (TIMEOUT != 0) && (((TIMEOUT - 1) >> CTW) == 0);
  localparam logic [CTW-1:0] WD_LAST = CTW'(TIMEOUT - 1);

  seq_state_t     state_q;
  logic [PCW-1:0] pc_q, pc_d;
  logic [PCW-1:0] entry_pc;
  logic           busy_q, ack_q, timeout_q;
  logic           running, start_acc, retire, halt_ret, wd_hit;
  logic [CTW-1:0] cycle_ct, inst_ct;

  assign running   = (state_q == S_RUN);
  assign start_acc = ((state_q == S_IDLE) || (state_q == S_DONE)) && Start;
  assign retire    = running && !Stall;
  assign halt_ret  = retire && HaltInst;
  assign wd_hit    = WD_EN && (cycle_ct == WD_LAST);

  // Entry address lookup; out-of-range selections fall back to program 0.
  always_comb begin
    entry_pc = PROG_BASE[0 +: PCW];
    for (int i = 0; i < PROGS; i++) begin
      if (ProgSel == SW'(i)) begin
        entry_pc = PROG_BASE[i*PCW +: PCW];
      end
    end
  end

  // Next PC for a retiring instruction: halt, absolute, conditional relative, sequential.
  always_comb begin
    pc_d = pc_q + PCW'(1);
    if (HaltInst) begin
      pc_d = pc_q;
    end else if (BranchAbs) begin
      pc_d = Target;
    end else if (BranchRelEn && cond_true(CondSel, ALU_equals, ALU_lt)) begin
      pc_d = pc_q + Target;
    end
  end

  // Run-control FSM with registered status outputs and the PC register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_q   <= S_RUN;
            pc_q      <= entry_pc;
            busy_q    <= 1'b1;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (retire) begin
            pc_q <= pc_d;
          end
          // A halt retiring in the watchdog's last cycle is a normal finish.
          if (halt_ret) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
          end else if (wd_hit) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            ack_q     <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CTW)) u_cycle_ct (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (start_acc),
    .inc   (running),
    .q     (cycle_ct)
  );

  sat_counter #(.W(CTW)) u_inst_ct (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (start_acc),
    .inc   (retire),
    .q     (inst_ct)
  );

  assign ProgCtr = pc_q;
  assign Busy    = busy_q;
  assign Ack     = ack_q;
  assign Timeout = timeout_q;
  assign CycleCt = cycle_ct;
  assign InstCt  = inst_ct;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: three configurations share one stimulus stream
// and each is compared against a behavioural model every cycle.
module tb_inst_sequencer;

  localparam int PCW   = 10;
  localparam int PROGS = 3;
  localparam logic [PROGS*PCW-1:0] BASE = {10'h2C0, 10'h100, 10'h040};
  localparam int ND = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic           Clk = 1'b0;
  logic           Reset_n;
  logic           Start;
  logic [1:0]     ProgSel;
  logic           BranchAbs, BranchRelEn;
  logic [1:0]     CondSel;
  logic           ALU_equals, ALU_lt;
  logic [PCW-1:0] Target;
  logic           HaltInst, Stall;

  logic [PCW-1:0] pc_w   [ND];
  logic           busy_w [ND];
  logic           ack_w  [ND];
  logic           tmo_w  [ND];
  logic [15:0]    cyc_w  [ND];
  logic [15:0]    inst_w [ND];
  logic [3:0]     cyc_c, inst_c;

  assign cyc_w[2]  = {12'd0, cyc_c};
  assign inst_w[2] = {12'd0, inst_c};

  always #5 Clk = ~Clk;

  // d0: long watchdog, d1: short watchdog, d2: 4-bit counters without watchdog
  inst_sequencer #(.PCW(PCW), .PROGS(PROGS), .PROG_BASE(BASE), .CTW(16), .TIMEOUT(50)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel), .BranchAbs(BranchAbs),
    .BranchRelEn(BranchRelEn), .CondSel(CondSel), .ALU_equals(ALU_equals), .ALU_lt(ALU_lt),
    .Target(Target), .HaltInst(HaltInst), .Stall(Stall), .ProgCtr(pc_w[0]), .Busy(busy_w[0]),
    .Ack(ack_w[0]), .Timeout(tmo_w[0]), .CycleCt(cyc_w[0]), .InstCt(inst_w[0]));

  inst_sequencer #(.PCW(PCW), .PROGS(PROGS), .PROG_BASE(BASE), .CTW(16), .TIMEOUT(8)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel), .BranchAbs(BranchAbs),
    .BranchRelEn(BranchRelEn), .CondSel(CondSel), .ALU_equals(ALU_equals), .ALU_lt(ALU_lt),
    .Target(Target), .HaltInst(HaltInst), .Stall(Stall), .ProgCtr(pc_w[1]), .Busy(busy_w[1]),
    .Ack(ack_w[1]), .Timeout(tmo_w[1]), .CycleCt(cyc_w[1]), .InstCt(inst_w[1]));

  inst_sequencer #(.PCW(PCW), .PROGS(PROGS), .PROG_BASE(BASE), .CTW(4), .TIMEOUT(0)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel), .BranchAbs(BranchAbs),
    .BranchRelEn(BranchRelEn), .CondSel(CondSel), .ALU_equals(ALU_equals), .ALU_lt(ALU_lt),
    .Target(Target), .HaltInst(HaltInst), .Stall(Stall), .ProgCtr(pc_w[2]), .Busy(busy_w[2]),
    .Ack(ack_w[2]), .Timeout(tmo_w[2]), .CycleCt(cyc_c), .InstCt(inst_c));

  // Reference model state
  int cfg_to  [ND] = '{50, 8, 0};
  int cfg_max [ND] = '{65535, 65535, 15};
  int entry   [PROGS] = '{'h040, 'h100, 'h2C0};
  int m_mode [ND];
  int m_pc   [ND];
  int m_cyc  [ND];
  int m_inst [ND];
  int m_ack  [ND];
  int m_tmo  [ND];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_mode[d] = M_IDLE; m_pc[d] = 0; m_cyc[d] = 0; m_inst[d] = 0; m_ack[d] = 0; m_tmo[d] = 0;
    end
  endtask

  // One clock edge of every model, from the currently applied inputs.
  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      if (m_mode[d] != M_RUN) begin
        if (Start) begin
          m_pc[d]   = (int'(ProgSel) < PROGS) ? entry[int'(ProgSel)] : entry[0];
          m_cyc[d]  = 0;
          m_inst[d] = 0;
          m_ack[d]  = 0;
          m_tmo[d]  = 0;
          m_mode[d] = M_RUN;
        end
      end else begin
        automatic bit wd   = (cfg_to[d] != 0) && (m_cyc[d] == cfg_to[d] - 1);
        automatic bit halt = !Stall && HaltInst;
        automatic int off  = (int'(Target) >= 512) ? int'(Target) - 1024 : int'(Target);
        automatic bit take;
        case (CondSel)
          2'b00:   take = 1'b1;
          2'b01:   take = ALU_equals;
          2'b10:   take = ALU_lt;
          default: take = ALU_equals || ALU_lt;
        endcase
        if (m_cyc[d] < cfg_max[d]) m_cyc[d] = m_cyc[d] + 1;
        if (!Stall) begin
          if (m_inst[d] < cfg_max[d]) m_inst[d] = m_inst[d] + 1;
          if (HaltInst)                m_pc[d] = m_pc[d];
          else if (BranchAbs)          m_pc[d] = int'(Target);
          else if (BranchRelEn && take) m_pc[d] = (m_pc[d] + off + 1024) % 1024;
          else                         m_pc[d] = (m_pc[d] + 1) % 1024;
        end
        if (halt) begin
          m_mode[d] = M_DONE; m_ack[d] = 1;
        end else if (wd) begin
          m_mode[d] = M_DONE; m_ack[d] = 1; m_tmo[d] = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s.d%0d.pc", tag, d),   longint'(pc_w[d]),   longint'(m_pc[d]));
      chk($sformatf("%s.d%0d.busy", tag, d), longint'(busy_w[d]), longint'(m_mode[d] == M_RUN));
      chk($sformatf("%s.d%0d.ack", tag, d),  longint'(ack_w[d]),  longint'(m_ack[d]));
      chk($sformatf("%s.d%0d.tmo", tag, d),  longint'(tmo_w[d]),  longint'(m_tmo[d]));
      chk($sformatf("%s.d%0d.cyc", tag, d),  longint'(cyc_w[d]),  longint'(m_cyc[d]));
      chk($sformatf("%s.d%0d.inst", tag, d), longint'(inst_w[d]), longint'(m_inst[d]));
    end
  endtask

  task automatic drv(input logic st, input logic [1:0] sel, input logic abs, input logic rel,
                     input logic [1:0] cs, input logic eq, input logic lt,
                     input logic [9:0] tgt, input logic halt, input logic stall);
    Start = st; ProgSel = sel; BranchAbs = abs; BranchRelEn = rel; CondSel = cs;
    ALU_equals = eq; ALU_lt = lt; Target = tgt; HaltInst = halt; Stall = stall;
  endtask

  task automatic plain();
    drv(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
  endtask

  // Inputs are applied at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input string tag);
    @(posedge Clk);
    if (Reset_n) model_step();
    @(negedge Clk);
    check_all(tag);
  endtask

  // Asynchronous reset asserted between edges, with Start held high while in reset.
  task automatic do_reset(input string tag);
    #2 Reset_n = 1'b0;
    #1 model_reset();
    check_all({tag, ".async"});
    chk({tag, ".pc0"}, longint'(pc_w[0]), 0);
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check_all({tag, ".held"});
    Reset_n = 1'b1;
    Start = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    plain();
    Start = 1'b1;
    model_reset();
    @(negedge Clk);
    check_all("por");
    step("por_start");
    Reset_n = 1'b1;
    plain();

    // Reset in the middle of a run at PC 0x05A
    drv(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0); step("t1.start");
    drv(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 10'h05A, 1'b0, 1'b0); step("t1.jmp");
    chk("t1.pc05a", longint'(pc_w[0]), 'h05A);
    chk("t1.busy", longint'(busy_w[0]), 1);
    do_reset("t1.rst");
    chk("t1.busy_after", longint'(busy_w[0]), 0);

    // Program 1 entry, five plain instructions, then halt
    drv(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0); step("t2.start");
    chk("t2.entry", longint'(pc_w[0]), 'h100);
    chk("t2.busy", longint'(busy_w[0]), 1);
    plain();
    for (int i = 0; i < 5; i++) step("t2.run");
    HaltInst = 1'b1; step("t2.halt");
    chk("t2.ack", longint'(ack_w[0]), 1);
    chk("t2.inst", longint'(inst_w[0]), 6);
    chk("t2.pc", longint'(pc_w[0]), 'h105);
    plain(); step("t2.hold");
    chk("t2.pc_hold", longint'(pc_w[0]), 'h105);

    // Conditional relative branch taken and not taken
    drv(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0); step("t3.start");
    drv(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 10'h010, 1'b0, 1'b0); step("t3.jmp");
    drv(1'b0, 2'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 10'h3FE, 1'b0, 1'b0); step("t3.taken");
    chk("t3.taken_pc", longint'(pc_w[0]), 'h00E);
    drv(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 10'h010, 1'b0, 1'b0); step("t3.jmp2");
    drv(1'b0, 2'd0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 10'h3FE, 1'b0, 1'b0); step("t3.nottaken");
    chk("t3.nottaken_pc", longint'(pc_w[0]), 'h011);
    plain(); HaltInst = 1'b1; step("t3.halt");
    plain();

    // Stalled halt
    drv(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0); step("t4.start");
    drv(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 10'h020, 1'b0, 1'b0); step("t4.jmp");
    drv(1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 10'h155, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("t4.stall");
    chk("t4.pc", longint'(pc_w[0]), 'h020);
    chk("t4.inst", longint'(inst_w[0]), 1);
    chk("t4.cyc", longint'(cyc_w[0]), 4);
    chk("t4.busy", longint'(busy_w[0]), 1);
    drv(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0); step("t4.halt");
    chk("t4.ack", longint'(ack_w[0]), 1);
    chk("t4.inst2", longint'(inst_w[0]), 2);
    plain();

    // Self-loop: watchdogs fire, Start during RUN ignored, 4-bit counters saturate
    drv(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0); step("t5.start");
    drv(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 10'h040, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      Start = (i >= 2 && i <= 4);
      step("t5.loop");
    end
    Start = 1'b0;
    chk("t5.d1.ack", longint'(ack_w[1]), 1);
    chk("t5.d1.tmo", longint'(tmo_w[1]), 1);
    chk("t5.d1.cyc", longint'(cyc_w[1]), 8);
    chk("t5.d0.busy", longint'(busy_w[0]), 1);
    for (int i = 9; i <= 50; i++) step("t5.loop2");
    chk("t5.d0.tmo", longint'(tmo_w[0]), 1);
    chk("t5.d0.cyc", longint'(cyc_w[0]), 50);
    chk("t6.d2.cyc_sat", longint'(cyc_w[2]), 'hF);
    chk("t6.d2.inst_sat", longint'(inst_w[2]), 'hF);
    chk("t6.d2.busy", longint'(busy_w[2]), 1);
    plain(); HaltInst = 1'b1; step("t5.halt");
    chk("t6.d2.ack", longint'(ack_w[2]), 1);
    chk("t6.d2.tmo", longint'(tmo_w[2]), 0);
    plain();

    // PC wrap-around and out-of-range program select
    drv(1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0); step("t6.start");
    chk("t6.sel3", longint'(pc_w[0]), 'h040);
    drv(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 10'h3FF, 1'b0, 1'b0); step("t6.jmp");
    plain(); step("t6.wrap");
    chk("t6.wrap_pc", longint'(pc_w[0]), 'h000);
    HaltInst = 1'b1; step("t6.halt");
    drv(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0); step("t6.start2");
    chk("t6.sel2", longint'(pc_w[0]), 'h2C0);
    plain(); HaltInst = 1'b1; step("t6.halt2");
    plain();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      Start       = ($urandom_range(0, 7) == 0);
      ProgSel     = 2'($urandom_range(0, 3));
      BranchAbs   = ($urandom_range(0, 7) == 0);
      BranchRelEn = ($urandom_range(0, 3) == 0);
      CondSel     = 2'($urandom_range(0, 3));
      ALU_equals  = 1'($urandom_range(0, 1));
      ALU_lt      = 1'($urandom_range(0, 1));
      Target      = 10'($urandom_range(0, 1023));
      HaltInst    = ($urandom_range(0, 23) == 0);
      Stall       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) do_reset("rnd.rst");
      else step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
